// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : multi_debouncer
// Purpose  : Multi-channel input debouncer with synchroniser, stability
//            counter, rise/fall strobes and optional auto-repeat strobe.
//            Optional feature macro: MULTI_DEBOUNCER_REPEAT_EN
// Revision : 1.0 - initial release
// ============================================================================
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                res,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt,
    output logic                any_event
);

    localparam int c_cnt_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES - 1);

    if (CHANNELS < 1 || STABLE_CYCLES < 1 || SYNC_STAGES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("multi_debouncer: illegal parameter combination");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_cnt_w-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_s;
        logic                   w_upd;

        assign w_s   = r_sync[SYNC_STAGES-1];
        // The level flips only after the synchronised input has disagreed
        // with it for STABLE_CYCLES consecutive samples.
        assign w_upd = (w_s != r_level) && (r_cnt == c_cnt_max);

        always_ff @(posedge clk) begin
            if (res) begin
                r_sync  <= '0;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], in[g]};
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (w_upd) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                    r_rise  <= w_s;
                    r_fall  <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign level[g] = r_level;
        assign rise[g]  = r_rise;
        assign fall[g]  = r_fall;

`ifdef MULTI_DEBOUNCER_REPEAT_EN
        localparam int c_rmax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int c_rw   = (c_rmax > 1) ? $clog2(c_rmax + 1) : 1;
        localparam logic [c_rw-1:0] c_del_m1 = c_rw'(REPEAT_DELAY - 1);
        localparam logic [c_rw-1:0] c_per_m1 = c_rw'(REPEAT_PERIOD - 1);

        logic [c_rw-1:0] r_rcnt;
        logic            r_rphase;
        logic            r_rpt;

        // r_rphase selects the initial delay (0) or the steady repeat period (1).
        always_ff @(posedge clk) begin
            if (res) begin
                r_rcnt   <= '0;
                r_rphase <= 1'b0;
                r_rpt    <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (w_upd) begin
                    r_rcnt   <= '0;
                    r_rphase <= 1'b0;
                end else if (r_level) begin
                    if (r_rcnt == (r_rphase ? c_per_m1 : c_del_m1)) begin
                        r_rpt    <= 1'b1;
                        r_rcnt   <= '0;
                        r_rphase <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
            end
        end

        assign rpt[g] = r_rpt;
`else
        assign rpt[g] = 1'b0;
`endif
    end

    assign any_event = |(rise | fall);

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_debouncer
// Purpose  : Scoreboard bench for multi_debouncer (4 channels, 4-cycle filter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       res;
    logic [3:0] in;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rpt;
    logic       any_event;

    multi_debouncer #(
        .CHANNELS      (4),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk       (clk),
        .res       (res),
        .in        (in),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .rpt       (rpt),
        .any_event (any_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] p;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] p);
        ev_t e;
        e.cyc = c;
        e.r   = r;
        e.f   = f;
        e.p   = p;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    // Monitor: any strobe activity is matched against the front of the queue.
    always @(negedge clk) begin
        ev_t e;
        if (any_event || (|rise) || (|fall) || (|rpt)) begin
            if (q.size() == 0) begin
                check("unexpected_event", {any_event, rise, fall, rpt}, 32'h0);
            end else begin
                e = q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("rise", rise, e.r);
                check("fall", fall, e.f);
                check("rpt", rpt, e.p);
                check("any_event", any_event, |(e.r | e.f));
                check("rise_fall_excl", rise & fall, 32'h0);
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("missed_event", {any_event, rise, fall, rpt}, {|(e.r | e.f), e.r, e.f, e.p});
        end
    end

    initial begin
        int c0;
        res = 1'b1;
        in  = 4'hF;
        repeat (3) begin
            tick();
            check("reset_level", level, 32'h0);
        end

        // Inputs held high through reset re-debounce as a rise.
        res = 1'b0;
        push(cyc + 6, 4'hF, 4'h0, 4'h0);
        wait_n(5);
        check("post_reset_early", level, 32'h0);
        wait_n(3);
        check("post_reset_level", level, 32'hF);
        in = 4'h0;
        push(cyc + 6, 4'h0, 4'hF, 4'h0);
        wait_n(8);
        check("all_released", level, 32'h0);

        // Clean press and release on channel 0.
        in[0] = 1'b1;
        push(cyc + 6, 4'h1, 4'h0, 4'h0);
        wait_n(5);
        check("press_early", level, 32'h0);
        wait_n(3);
        check("press_level", level, 32'h1);
        in[0] = 1'b0;
        push(cyc + 6, 4'h0, 4'h1, 4'h0);
        wait_n(8);
        check("release_level", level, 32'h0);

        // Bounce on channel 1 never reaches four stable samples.
        in[1] = 1'b1; wait_n(3);
        in[1] = 1'b0; wait_n(1);
        in[1] = 1'b1; wait_n(3);
        in[1] = 1'b0; wait_n(8);
        check("bounce_level", level, 32'h0);

        // Simultaneous rise on ch2 and fall on ch3.
        in[3] = 1'b1;
        push(cyc + 6, 4'h8, 4'h0, 4'h0);
        wait_n(8);
        check("ch3_high", level, 32'h8);
        in[2] = 1'b1;
        in[3] = 1'b0;
        push(cyc + 6, 4'h4, 4'h8, 4'h0);
        wait_n(8);
        check("simul_level", level, 32'h4);
        in[2] = 1'b0;
        push(cyc + 6, 4'h0, 4'h4, 4'h0);
        wait_n(8);
        check("simul_release", level, 32'h0);

        // Reset mid-count discards progress.
        in[0] = 1'b1;
        wait_n(3);
        res = 1'b1;
        tick();
        check("midreset_level", level, 32'h0);
        res = 1'b0;
        push(cyc + 6, 4'h1, 4'h0, 4'h0);
        wait_n(5);
        check("midreset_early", level, 32'h0);
        wait_n(3);
        check("midreset_rise", level, 32'h1);
        in[0] = 1'b0;
        push(cyc + 6, 4'h0, 4'h1, 4'h0);
        wait_n(8);
        check("midreset_release", level, 32'h0);

        // Long hold on channel 0: repeat strobes only with the feature enabled.
        in[0] = 1'b1;
        c0 = cyc;
        push(c0 + 6, 4'h1, 4'h0, 4'h0);
`ifdef MULTI_DEBOUNCER_REPEAT_EN
        push(c0 + 16, 4'h0, 4'h0, 4'h1);
        push(c0 + 21, 4'h0, 4'h0, 4'h1);
        push(c0 + 26, 4'h0, 4'h0, 4'h1);
        push(c0 + 31, 4'h0, 4'h0, 4'h1);
`endif
        wait_n(28);
        check("hold_level", level, 32'h1);
        in[0] = 1'b0;
        push(c0 + 34, 4'h0, 4'h1, 4'h0);
        wait_n(16);
        check("hold_release", level, 32'h0);

        wait_n(4);
        check("queue_drained", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised, multi-channel successor to the single-input push-button debouncer. Each channel synchronises a raw asynchronous input and accepts a new level only after it has been stable for a programmable number of clock cycles. Each channel outputs a clean level plus one-cycle rise and fall strobes, and optionally an auto-repeat strobe while held. It sits between board-level buttons/switches and the control FSMs, replacing per-button debouncer instances.

## Interface
- CHANNELS, 4, number of independent inputs (>=1)
- STABLE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a new level (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- REPEAT_DELAY, 50000000, cycles from accepted rise to first repeat strobe (used only with repeat feature)
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat strobes (used only with repeat feature)

- clk  input  1  system clock, all logic on rising edge
- res  input  1  synchronous, active-high reset
- in  input  CHANNELS  raw asynchronous inputs
- level  output  CHANNELS  debounced level per channel
- rise  output  CHANNELS  one-cycle strobe when level goes 0->1
- fall  output  CHANNELS  one-cycle strobe when level goes 1->0
- rpt  output  CHANNELS  one-cycle auto-repeat strobe (constant 0 without macro)
- any_event  output  1  OR of all rise and fall bits in the current cycle

## Operation
- Per channel: SYNC_STAGES-deep flop chain; last stage is `s`.
- Stability counter `cnt`, width max(1, $clog2(STABLE_CYCLES)).
- Each cycle:
  - s == level: cnt <= 0. Any bounce restarts the count.
  - s != level and cnt == STABLE_CYCLES-1: level <= s, cnt <= 0, and rise or fall asserted for exactly this one update cycle.
  - s != level otherwise: cnt <= cnt+1.
- Channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle, and any_event is 1 in that cycle.
- rise, fall and rpt are registered. any_event is a combinational OR of the registered strobes.
- rise and fall are never both 1 on one channel in the same cycle.
- STABLE_CYCLES = 1: level follows `s` one cycle later, with no filtering.

## Timing
- Reset (res=1 at an edge) clears the synchroniser, level, cnt, repeat counters and all strobes to 0. Reset mid-count discards the progress.
- An input held high through reset is re-debounced as a normal rise after reset is released. No strobe occurs during reset.
- Latency: if `in` changes before edge 1 and stays stable, `s` reflects it after edge SYNC_STAGES. level, rise and fall update after edge SYNC_STAGES+STABLE_CYCLES.
- A glitch shorter than STABLE_CYCLES cycles at `s` never changes level.
- Counters never wrap: cnt saturates by clearing at STABLE_CYCLES-1. Repeat counter behaviour is defined under Configuration.

## Configuration
- Macro: MULTI_DEBOUNCER_REPEAT_EN.
- Defined:
  - Per-channel repeat counter, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - Counter clears on the rise cycle and counts while level=1.
  - rpt pulses for one cycle REPEAT_DELAY cycles after the rise strobe, then every REPEAT_PERIOD cycles while level stays 1.
  - fall or reset clears the counter and stops repetition immediately. rpt is never asserted in the same cycle as rise or fall.
- Undefined: no repeat counters are synthesised and rpt is tied to 0. REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Test plan
All tests use CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4 unless stated.

- Reset: hold res for 3 edges with in=4'hF -> level=0, rise=fall=rpt=0 and any_event=0 throughout. After release, rise=4'hF for one cycle at edge 6 after release, and level=4'hF thereafter.
- Clean press: in[0] 0->1 before edge 1 -> level[0]=1 and rise[0]=1 after edge 6 only. rise[0]=0 at edge 7.
- Bounce: in[1] toggles high 3 cycles, low 1, high 3, low -> level[1] stays 0, no strobes.
- Simultaneous: in[2] 0->1 and in[3] 1->0 (from debounced 1) at the same cycle -> rise[2]=1, fall[3]=1 and any_event=1 in the same single cycle.
- Reset mid-count: in[0] high for 3 cycles, then res for 1 edge with in held -> level[0] rises only 6 edges after reset release, not earlier.
- Repeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5): hold in[0] -> rpt[0] pulses 10 cycles after rise[0], then every 5 cycles. Release in[0] -> fall[0], and no further rpt[0] pulses.
